// File: rtl/pwr_btn_pkg.sv
// Power-button sequencer shared definitions: one-hot state encoding,
// tick counter width and default tick counts. Optional feature macro: PWRBTN_WDT_EN.
package pwr_btn_pkg;

   localparam int CNT_W = 8;
   typedef logic [CNT_W-1:0] cnt_t;

   localparam int DEF_PULSE_TICKS   = 2;
   localparam int DEF_HOLDOFF_TICKS = 8;
   localparam int DEF_OVR_MAX_TICKS = 80;

   // One-hot bit positions
   localparam int B_IDLE     = 0;
   localparam int B_ARMED    = 1;
   localparam int B_PULSE    = 2;
   localparam int B_OVERRIDE = 3;
   localparam int B_HOLDOFF  = 4;
   localparam int B_FAULT    = 5;

   localparam logic [5:0] S_IDLE     = 6'b000001;
   localparam logic [5:0] S_ARMED    = 6'b000010;
   localparam logic [5:0] S_PULSE    = 6'b000100;
   localparam logic [5:0] S_OVERRIDE = 6'b001000;
   localparam logic [5:0] S_HOLDOFF  = 6'b010000;
   localparam logic [5:0] S_FAULT    = 6'b100000;

endpackage

// File: rtl/pwr_btn_seq_if.sv
// Button-event inputs and PCH-side outputs of the power-button sequencer.
// slave: sequencer side (events in, PwrBtnN/ForceOff/Busy/BtnFault out); master: driver side.
interface pwr_btn_seq_if;

   logic Strobe125ms;
   logic BtnInterrupt;
   logic BtnLongN;
   logic BtnRelease;
   logic PwrBtnN;
   logic ForceOff;
   logic Busy;
   logic BtnFault;

   modport master (
      output Strobe125ms, BtnInterrupt, BtnLongN, BtnRelease,
      input  PwrBtnN, ForceOff, Busy, BtnFault
   );

   modport slave (
      input  Strobe125ms, BtnInterrupt, BtnLongN, BtnRelease,
      output PwrBtnN, ForceOff, Busy, BtnFault
   );

endinterface

// File: rtl/pwr_btn_tick_timer.sv
// 8-bit loadable down-counter of 125 ms ticks; saturates at 0.
// Ports: clk_i, rst_ni, load_i, load_val_i, tick_i in; expire_o out (count==1 and tick).
module pwr_btn_tick_timer
   import pwr_btn_pkg::*;
(
   input  logic clk_i,
   input  logic rst_ni,
   input  logic load_i,
   input  cnt_t load_val_i,
   input  logic tick_i,
   output logic expire_o
);

   cnt_t cnt_q, cnt_d;

   // Load wins over a same-cycle tick, so the entry-cycle strobe is not counted
   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = load_val_i;
      else if (tick_i && cnt_q != '0)
         cnt_d = cnt_q - cnt_t'(1);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign expire_o = tick_i && (cnt_q == cnt_t'(1));

endmodule

// File: rtl/pwr_btn_seq.sv
// Power-button sequencer: turns debounced press/long-press/release events into
// PCH power-button pulse, forced-off override and post-action holdoff.
// Ports: SlowClock, MainReset (async, active-low), bus (pwr_btn_seq_if.slave).
// Optional macro PWRBTN_WDT_EN adds a stuck-button limit in OVERRIDE and the FAULT state.
module pwr_btn_seq
   import pwr_btn_pkg::*;
#(
   parameter int PULSE_TICKS   = DEF_PULSE_TICKS,
   parameter int HOLDOFF_TICKS = DEF_HOLDOFF_TICKS,
   parameter int OVR_MAX_TICKS = DEF_OVR_MAX_TICKS
) (
   input  logic          SlowClock,
   input  logic          MainReset,
   pwr_btn_seq_if.slave  bus
);

   logic [5:0] state_q, state_d;
   logic       pwr_btn_n_q, force_off_q, busy_q;
   logic       expire, tick, load;
   cnt_t       load_val;

   // Next state
   always_comb begin
      state_d = state_q;
      unique case (1'b1)
         state_q[B_IDLE]:
            if (bus.BtnInterrupt) state_d = S_ARMED;
         state_q[B_ARMED]:
            if (!bus.BtnLongN)      state_d = S_OVERRIDE;
            else if (bus.BtnRelease) state_d = S_PULSE;
         state_q[B_PULSE]:
            if (expire) state_d = S_HOLDOFF;
         state_q[B_OVERRIDE]: begin
            if (bus.BtnRelease) state_d = S_HOLDOFF;
`ifdef PWRBTN_WDT_EN
            else if (expire)    state_d = S_FAULT;
`endif
         end
         state_q[B_HOLDOFF]:
            if (expire) state_d = S_IDLE;
`ifdef PWRBTN_WDT_EN
         state_q[B_FAULT]:
            if (bus.BtnRelease) state_d = S_HOLDOFF;
`endif
         default: state_d = S_IDLE;
      endcase
   end

   // Per-state tick budget, loaded on every state entry.
   // Without the watchdog the OVERRIDE value is held but never counted.
   always_comb begin
      load_val = '0;
      unique case (1'b1)
         state_d[B_PULSE]:    load_val = cnt_t'(PULSE_TICKS);
         state_d[B_OVERRIDE]: load_val = cnt_t'(OVR_MAX_TICKS);
         state_d[B_HOLDOFF]:  load_val = cnt_t'(HOLDOFF_TICKS);
         default:             load_val = '0;
      endcase
   end

   assign load = (state_d != state_q);

`ifdef PWRBTN_WDT_EN
   assign tick = bus.Strobe125ms;
`else
   assign tick = bus.Strobe125ms & ~state_q[B_OVERRIDE];
`endif

   pwr_btn_tick_timer u_timer (
      .clk_i      (SlowClock),
      .rst_ni     (MainReset),
      .load_i     (load),
      .load_val_i (load_val),
      .tick_i     (tick),
      .expire_o   (expire)
   );

   // Outputs are registered from the next state so they change on the state edge
   always_ff @(posedge SlowClock or negedge MainReset) begin
      if (!MainReset) begin
         state_q     <= S_IDLE;
         pwr_btn_n_q <= 1'b1;
         force_off_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         pwr_btn_n_q <= ~(state_d[B_PULSE] | state_d[B_OVERRIDE]);
         force_off_q <= state_d[B_OVERRIDE];
         busy_q      <= ~state_d[B_IDLE];
      end
   end

`ifdef PWRBTN_WDT_EN
   logic fault_q;

   always_ff @(posedge SlowClock or negedge MainReset) begin
      if (!MainReset)
         fault_q <= 1'b0;
      else
         fault_q <= state_d[B_FAULT];
   end

   assign bus.BtnFault = fault_q;
`else
   assign bus.BtnFault = 1'b0;
`endif

   assign bus.PwrBtnN  = pwr_btn_n_q;
   assign bus.ForceOff = force_off_q;
   assign bus.Busy     = busy_q;

endmodule

// File: tb/tb_pwr_btn_seq.sv
// Directed self-checking bench for pwr_btn_seq.
// Tick period is 4096 cycles for the reset and short-press cases, 16 afterwards.
module tb_pwr_btn_seq;

   logic clk = 1'b0;
   logic rst_n;

   pwr_btn_seq_if bus ();

   pwr_btn_seq #(
      .PULSE_TICKS   (2),
      .HOLDOFF_TICKS (8),
      .OVR_MAX_TICKS (4)
   ) dut (
      .SlowClock (clk),
      .MainReset (rst_n),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   int   n_vec = 0;
   int   n_bad = 0;
   int   tick_per = 4096;
   int   tick_cnt = 0;
   logic tick_en = 1'b0;

   always @(negedge clk) begin
      if (!tick_en) begin
         tick_cnt        <= 0;
         bus.Strobe125ms <= 1'b0;
      end else if (tick_cnt >= tick_per - 1) begin
         tick_cnt        <= 0;
         bus.Strobe125ms <= 1'b1;
      end else begin
         tick_cnt        <= tick_cnt + 1;
         bus.Strobe125ms <= 1'b0;
      end
   end

   task automatic chk(input string tag, input logic obs, input logic exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk_rng(input string tag, input int obs,
                          input int lo, input int hi);
      n_vec++;
      assert (obs >= lo && obs <= hi)
      else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      n_vec++;
      assert (obs == exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_int();
      bus.BtnInterrupt = 1'b1;
      @(negedge clk);
      bus.BtnInterrupt = 1'b0;
   endtask

   task automatic pulse_rel();
      bus.BtnRelease = 1'b1;
      @(negedge clk);
      bus.BtnRelease = 1'b0;
   endtask

   // Cycles until Busy drops, bounded
   task automatic wait_idle(input int max, output int n);
      n = 0;
      while (bus.Busy !== 1'b0 && n < max) begin
         @(negedge clk);
         n++;
      end
   endtask

   initial begin
      int n;
      int bad;

      rst_n            = 1'b0;
      bus.BtnInterrupt = 1'b0;
      bus.BtnLongN     = 1'b1;
      bus.BtnRelease   = 1'b0;
      cyc(3);

      chk("rst PwrBtnN", bus.PwrBtnN, 1'b1);
      chk("rst ForceOff", bus.ForceOff, 1'b0);
      chk("rst Busy", bus.Busy, 1'b0);
      chk("rst BtnFault", bus.BtnFault, 1'b0);

      rst_n   = 1'b1;
      tick_en = 1'b1;
      cyc(2);

      // Reset in the middle of a PULSE
      pulse_int();
      chk("arm Busy", bus.Busy, 1'b1);
      chk("arm PwrBtnN", bus.PwrBtnN, 1'b1);
      pulse_rel();
      chk("pulse start", bus.PwrBtnN, 1'b0);
      cyc(100);
      chk("pulse mid", bus.PwrBtnN, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("async rst PwrBtnN", bus.PwrBtnN, 1'b1);
      chk("async rst Busy", bus.Busy, 1'b0);
      cyc(2);
      rst_n = 1'b1;
      cyc(3);
      chk("post rst Busy", bus.Busy, 1'b0);
      chk("post rst PwrBtnN", bus.PwrBtnN, 1'b1);

      // Short press with 4096-cycle ticks; drop a press during HOLDOFF
      pulse_int();
      cyc(8000);
      chk("armed wait PwrBtnN", bus.PwrBtnN, 1'b1);
      chk("armed wait Busy", bus.Busy, 1'b1);
      pulse_rel();
      n = 0;
      while (bus.PwrBtnN === 1'b0 && n < 9000) begin
         @(negedge clk);
         n++;
      end
      chk_rng("short pulse width", n, 4097, 8192);
      chk("holdoff Busy", bus.Busy, 1'b1);
      chk("holdoff ForceOff", bus.ForceOff, 1'b0);
      pulse_int();
      chk("holdoff drop PwrBtnN", bus.PwrBtnN, 1'b1);
      n = 1;
      while (bus.Busy !== 1'b0 && n < 33000) begin
         @(negedge clk);
         n++;
      end
      chk_rng("holdoff length", n, 7 * 4096 + 1, 8 * 4096);
      cyc(5);
      chk("dropped press stays idle", bus.Busy, 1'b0);

      // Faster ticks from here on
      tick_en  = 1'b0;
      tick_per = 16;
      cyc(1);
      tick_en  = 1'b1;

      // Re-arm after holdoff
      pulse_int();
      chk("rearm Busy", bus.Busy, 1'b1);
      pulse_rel();
      n = 0;
      while (bus.PwrBtnN === 1'b0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk_rng("rearm pulse width", n, 17, 32);
      wait_idle(200, n);
      chk_rng("rearm holdoff", n, 113, 128);

      // IDLE ignores release and long-press
      pulse_rel();
      bus.BtnLongN = 1'b0;
      cyc(1);
      bus.BtnLongN = 1'b1;
      cyc(1);
      chk("idle ignore Busy", bus.Busy, 1'b0);
      chk("idle ignore PwrBtnN", bus.PwrBtnN, 1'b1);

      // Long press
      pulse_int();
      cyc(5);
      bus.BtnLongN = 1'b0;
      cyc(1);
      chk("long PwrBtnN", bus.PwrBtnN, 1'b0);
      chk("long ForceOff", bus.ForceOff, 1'b1);
      cyc(15);
      bus.BtnLongN = 1'b1;
      bad = 0;
`ifdef PWRBTN_WDT_EN
      repeat (16) begin
`else
      repeat (20 * 16) begin
`endif
         @(negedge clk);
         if (bus.PwrBtnN !== 1'b0 || bus.ForceOff !== 1'b1) bad++;
      end
      chk_int("long hold glitches", bad, 0);
      pulse_rel();
      chk("long rel PwrBtnN", bus.PwrBtnN, 1'b1);
      chk("long rel ForceOff", bus.ForceOff, 1'b0);
      chk("long rel Busy", bus.Busy, 1'b1);
      bad = 0;
      n = 0;
      while (bus.Busy !== 1'b0 && n < 200) begin
         if (bus.PwrBtnN !== 1'b1) bad++;
         @(negedge clk);
         n++;
      end
      chk_int("long no short pulse", bad, 0);
      chk_rng("long holdoff", n, 113, 128);

      // Long-press and release together in ARMED
      pulse_int();
      bus.BtnLongN   = 1'b0;
      bus.BtnRelease = 1'b1;
      cyc(1);
      bus.BtnLongN   = 1'b1;
      bus.BtnRelease = 1'b0;
      chk("simul ForceOff", bus.ForceOff, 1'b1);
      chk("simul PwrBtnN", bus.PwrBtnN, 1'b0);
      cyc(10);
      chk("simul ForceOff held", bus.ForceOff, 1'b1);
      pulse_rel();
      chk("simul rel ForceOff", bus.ForceOff, 1'b0);
      wait_idle(200, n);
      chk_rng("simul holdoff", n, 113, 128);

      // Stuck button
      pulse_int();
      bus.BtnLongN = 1'b0;
      cyc(1);
`ifdef PWRBTN_WDT_EN
      n = 1;
      while (bus.BtnFault !== 1'b1 && n < 200) begin
         if (n == 16) bus.BtnLongN = 1'b1;
         @(negedge clk);
         n++;
      end
      bus.BtnLongN = 1'b1;
      chk_rng("stuck fault time", n, 49, 64);
      chk("fault PwrBtnN", bus.PwrBtnN, 1'b1);
      chk("fault ForceOff", bus.ForceOff, 1'b0);
      chk("fault Busy", bus.Busy, 1'b1);
      pulse_rel();
      chk("fault clr BtnFault", bus.BtnFault, 1'b0);
      chk("fault clr Busy", bus.Busy, 1'b1);
`else
      cyc(15);
      bus.BtnLongN = 1'b1;
      bad = 0;
      repeat (400) begin
         @(negedge clk);
         if (bus.PwrBtnN !== 1'b0 || bus.BtnFault !== 1'b0) bad++;
      end
      chk_int("stuck no limit", bad, 0);
      pulse_rel();
      chk("stuck rel PwrBtnN", bus.PwrBtnN, 1'b1);
`endif
      wait_idle(200, n);
      chk_rng("stuck holdoff", n, 113, 128);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
